// File: rtl/row_driver_seq.sv
// Sequenced row driver: precharges the bit lines, then drives timed word-line pulses,
// either as an auto-incrementing multi-row scan (MAC) or as a single search-key drive (CAM).
module row_driver_seq #(
  parameter int ROWS    = 4,
  parameter int ADDR_W  = 2,
  parameter int PW_W    = 4,
  parameter int PRE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mac_en,
  input  logic              read_bar,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W:0]   row_count,
  input  logic [ROWS-1:0]   key,
  input  logic [PW_W-1:0]   pulse_w,
  output logic              busy,
  output logic              done,
  output logic              precharge,
  output logic [ADDR_W-1:0] row_idx,
  output logic [ROWS-1:0]   WL,
  output logic [ROWS-1:0]   WLB
);
  // state | meaning
  // IDLE  | waiting for start; outputs quiet
  // PRE   | bit-line precharge, word lines low, PRE_CYC cycles
  // DRIVE | word-line pulse for pulse_w cycles
  // DONE  | one-cycle done pulse, then IDLE
  typedef enum logic [1:0] {IDLE, PRE, DRIVE, DONE} state_t;

  localparam int PRE_W = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
  localparam logic [PRE_W-1:0]  PRE_LOAD = PRE_W'(PRE_CYC - 1);
  localparam logic [ADDR_W:0]   ROWS_V   = (ADDR_W + 1)'(ROWS);
  localparam logic [ADDR_W:0]   ONE_RC   = (ADDR_W + 1)'(1);

  state_t             state;
  logic               mac_q, rb_q;
  logic [ROWS-1:0]    key_q;
  logic [PW_W-1:0]    pw_q;
  logic [ADDR_W:0]    rows_left;
  logic [PRE_W-1:0]   pre_cnt;
  logic [PW_W-1:0]    drv_cnt;

  logic [ADDR_W:0]    rc_eff;
  logic [PW_W-1:0]    pw_eff;
  logic [ROWS-1:0]    onehot;

  always_comb begin
    rc_eff = row_count;
    if (row_count == '0) rc_eff = ONE_RC;
    else if (row_count > ROWS_V) rc_eff = ROWS_V;
    pw_eff = (pulse_w == '0) ? PW_W'(1) : pulse_w;
    onehot = ROWS'(1) << row_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mac_q     <= 1'b0;
      rb_q      <= 1'b0;
      key_q     <= '0;
      pw_q      <= '0;
      rows_left <= '0;
      pre_cnt   <= '0;
      drv_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      precharge <= 1'b0;
      row_idx   <= '0;
      WL        <= '0;
      WLB       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mac_q     <= mac_en;
            rb_q      <= read_bar;
            key_q     <= key;
            pw_q      <= pw_eff;
            rows_left <= rc_eff;
            pre_cnt   <= PRE_LOAD;
            if (mac_en) row_idx <= addr_start;
            busy      <= 1'b1;
            precharge <= 1'b1;
            state     <= PRE;
          end
        end
        PRE: begin
          if (pre_cnt == '0) begin
            precharge <= 1'b0;
            drv_cnt   <= pw_q - PW_W'(1);
            WL        <= mac_q ? (rb_q ? '0 : onehot) : key_q;
            WLB       <= mac_q ? (rb_q ? onehot : '0) : ~key_q;
            state     <= DRIVE;
          end else begin
            pre_cnt <= pre_cnt - PRE_W'(1);
          end
        end
        DRIVE: begin
          if (drv_cnt == '0) begin
            WL  <= '0;
            WLB <= '0;
            if (mac_q && rows_left > ONE_RC) begin
              // ROWS is a power of two, so the address naturally wraps
              row_idx   <= row_idx + ADDR_W'(1);
              rows_left <= rows_left - ONE_RC;
              pre_cnt   <= PRE_LOAD;
              precharge <= 1'b1;
              state     <= PRE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            drv_cnt <= drv_cnt - PW_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_row_driver_seq.sv
// Bench for row_driver_seq: a trace model builds the expected per-cycle output sequence of
// each accepted operation; every cycle the DUT outputs are compared against it.
module tb_row_driver_seq;
  localparam int ROWS = 4, ADDR_W = 2, PW_W = 4, PRE_CYC = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, mac_en = 1'b0, read_bar = 1'b0;
  logic [ADDR_W-1:0] addr_start = '0;
  logic [ADDR_W:0]   row_count = '0;
  logic [ROWS-1:0]   key = '0;
  logic [PW_W-1:0]   pulse_w = '0;
  logic busy, done, precharge;
  logic [ADDR_W-1:0] row_idx;
  logic [ROWS-1:0]   WL, WLB;

  row_driver_seq #(.ROWS(ROWS), .ADDR_W(ADDR_W), .PW_W(PW_W), .PRE_CYC(PRE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mac_en(mac_en), .read_bar(read_bar),
    .addr_start(addr_start), .row_count(row_count), .key(key), .pulse_w(pulse_w),
    .busy(busy), .done(done), .precharge(precharge), .row_idx(row_idx), .WL(WL), .WLB(WLB));

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, pre;
    logic [ADDR_W-1:0] row;
    logic [ROWS-1:0] wl, wlb;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic [ADDR_W-1:0] last_row;
  int total = 0, bad = 0;

  // Expand one accepted request into the full list of per-cycle outputs it must produce.
  task automatic build_trace();
    int rc, pw, r;
    exp_t e;
    rc = (row_count == 0) ? 1 : ((row_count > ROWS) ? ROWS : int'(row_count));
    pw = (pulse_w == 0) ? 1 : int'(pulse_w);
    if (!mac_en) rc = 1;
    r = mac_en ? int'(addr_start) : int'(last_row);
    for (int k = 0; k < rc; k++) begin
      for (int c = 0; c < PRE_CYC; c++) begin
        e = '0; e.busy = 1; e.pre = 1; e.row = ADDR_W'(r);
        q.push_back(e);
      end
      for (int c = 0; c < pw; c++) begin
        e = '0; e.busy = 1; e.row = ADDR_W'(r);
        if (mac_en) begin
          if (read_bar) e.wlb = ROWS'(1) << r;
          else          e.wl  = ROWS'(1) << r;
        end else begin
          e.wl = key; e.wlb = ~key;
        end
        q.push_back(e);
      end
      if (k < rc - 1) r = (r + 1) % ROWS;
    end
    e = '0; e.busy = 1; e.done = 1; e.row = ADDR_W'(r);
    q.push_back(e);
    last_row = ADDR_W'(r);
  endtask

  task automatic compare(input string name);
    exp_t act;
    act = '{busy, done, precharge, row_idx, WL, WLB};
    total++;
    if (act !== cur) begin
      bad++;
      $display("FAIL %s t=%0t actual busy/done/pre/row/WL/WLB=%b/%b/%b/%0d/%b/%b required=%b/%b/%b/%0d/%b/%b",
               name, $time, act.busy, act.done, act.pre, act.row, act.wl, act.wlb,
               cur.busy, cur.done, cur.pre, cur.row, cur.wl, cur.wlb);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (!cur.busy && start) build_trace();
      if (q.size() > 0) cur = q.pop_front();
      else begin cur = '0; cur.row = last_row; end
    end
    #1;
    compare("cycle");
  endtask

  task automatic run_op(input logic m, input logic rb, input logic [ADDR_W-1:0] as,
                        input logic [ADDR_W:0] rc, input logic [ROWS-1:0] k,
                        input logic [PW_W-1:0] pw, input bit disturb,
                        input int exp_len, input logic [2*ROWS-1:0] exp_first,
                        input string name);
    int n;
    logic [2*ROWS-1:0] first;
    mac_en = m; read_bar = rb; addr_start = as; row_count = rc; key = k; pulse_w = pw;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; first = '0;
    while (busy && n < 200) begin
      n++;
      if (n == PRE_CYC + 1) first = {WL, WLB};
      if (disturb && n == PRE_CYC + 1) begin
        key = ~key; addr_start = addr_start + 1'b1; read_bar = ~read_bar; start = 1'b1;
      end else start = 1'b0;
      step();
    end
    start = 1'b0;
    if (n >= 200) begin
      bad++; total++;
      $display("FAIL %s_timeout actual=busy_stuck required=idle", name);
    end
    check_val({name, "_len"}, n, exp_len);
    if (exp_len > 0) check_val({name, "_first_wl_wlb"}, int'(first), int'(exp_first));
  endtask

  initial begin
    cur = '0; last_row = '0;
    #2;
    #1 compare("reset_state");
    #20;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();

    run_op(1, 0, 2, 1, 4'h0, 2, 0, 4, 8'b0100_0000, "t1_mac_read");
    run_op(1, 1, 1, 1, 4'h0, 1, 0, 3, 8'b0000_0010, "t2_mac_qb");
    run_op(1, 0, 3, 3, 4'h0, 1, 0, 7, 8'b1000_0000, "t3_wrap_scan");
    check_val("t3_final_row", int'(row_idx), 1);
    run_op(0, 1, 3, 1, 4'b1010, 3, 0, 5, 8'b1010_0101, "t4_cam");
    run_op(0, 0, 0, 1, 4'b1010, 2, 1, 4, 8'b1010_0101, "t5_cam_disturb");
    run_op(1, 0, 0, 0, 4'h0, 0, 0, 3, 8'b0001_0000, "t5_zero_fields");
    run_op(1, 0, 1, 7, 4'h0, 1, 0, 9, 8'b0010_0000, "rc_clamp");
    repeat (2) step();

    // Reset during a MAC drive: outputs must clear without a clock edge.
    mac_en = 1; read_bar = 0; addr_start = 2; row_count = 4; pulse_w = 3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    q.delete(); cur = '0; last_row = '0;
    compare("t6_async_reset");
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();
    run_op(1, 1, 3, 2, 4'h0, 2, 0, 7, 8'b0000_1000, "t6_after_reset");

    for (int i = 0; i < 40; i++) begin
      logic m, rb;
      logic [ADDR_W-1:0] as;
      logic [ADDR_W:0] rc;
      logic [PW_W-1:0] pw;
      logic [ROWS-1:0] k;
      int rce, pwe, len;
      m = 1'($urandom); rb = 1'($urandom); as = ADDR_W'($urandom);
      rc = (ADDR_W+1)'($urandom); pw = PW_W'($urandom_range(0, 5)); k = ROWS'($urandom);
      rce = (rc == 0) ? 1 : ((rc > ROWS) ? ROWS : int'(rc));
      pwe = (pw == 0) ? 1 : int'(pw);
      len = m ? rce * (PRE_CYC + pwe) + 1 : PRE_CYC + pwe + 1;
      run_op(m, rb, as, rc, k, pw, 1'($urandom), len,
             m ? (rb ? {4'b0, 4'(1 << as)} : {4'(1 << as), 4'b0}) : {k, ~k}, "rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
